// File: rtl/axis_noise_generator_pkg.sv
// Shared constants and helpers for the additive-noise injector.
// Both noise lanes and the top import this package.
package axis_noise_generator_pkg;

  localparam int LANE_W  = 32;
  localparam int SHIFT_W = 5;
  localparam int NOISE_W = 10;
  localparam int SCALE_W = NOISE_W + (1 << SHIFT_W);
  localparam int SUM_W   = SCALE_W + 1;

  localparam logic [LANE_W-1:0] LFSR_POLY      = 32'h8020_0003;
  localparam logic [LANE_W-1:0] SEED_I_DEFAULT = 32'hACE1_2468;
  localparam logic [LANE_W-1:0] SEED_Q_DEFAULT = 32'h1357_9BDF;

  typedef logic [LANE_W-1:0] lane_t;

  // Galois form of x^32+x^22+x^2+x+1, shifting right.
  function automatic lane_t lfsr_step(input lane_t r);
    lane_t nxt;
    nxt = r >> 1;
    if (r[0]) nxt = nxt ^ LFSR_POLY;
    return nxt;
  endfunction

  // Sum of four sign-extended bytes; central-limit approximation of a Gaussian.
  function automatic logic [NOISE_W-1:0] byte_sum(input lane_t r);
    logic [NOISE_W-1:0] acc;
    acc = '0;
    for (int b = 0; b < 4; b++) begin
      acc = acc + {{(NOISE_W-8){r[8*b+7]}}, r[8*b +: 8]};
    end
    return acc;
  endfunction

endpackage

// File: rtl/axis_noise_generator_noise_lane.sv
// One noise lane: LFSR, byte-sum noise, programmable shift and saturating add.
// The result is combinational; the top registers it.
module axis_noise_generator_noise_lane
  import axis_noise_generator_pkg::*;
#(
  parameter logic [LANE_W-1:0] SEED = SEED_I_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               advance,
  input  logic [SHIFT_W-1:0] shift,
  input  logic [LANE_W-1:0]  sample,
  output logic [LANE_W-1:0]  result
);

  lane_t               state;
  logic [NOISE_W-1:0]  noise;
  logic signed [SCALE_W-1:0] noise_ext;
  logic signed [SCALE_W-1:0] scaled;
  logic [SUM_W-1:0]    total;
  logic                pos_ovf;
  logic                neg_ovf;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SEED;
    end else if (advance) begin
      state <= lfsr_step(state);
    end
  end

  // Noise uses the state before this beat's advance.
  assign noise     = byte_sum(state);
  assign noise_ext = {{(SCALE_W-NOISE_W){noise[NOISE_W-1]}}, noise};
  assign scaled    = noise_ext <<< shift;
  assign total     = {scaled[SCALE_W-1], scaled}
                   + {{(SUM_W-LANE_W){sample[LANE_W-1]}}, sample};

  assign pos_ovf = !total[SUM_W-1] && (|total[SUM_W-2:LANE_W-1]);
  assign neg_ovf =  total[SUM_W-1] && !(&total[SUM_W-2:LANE_W-1]);

  always_comb begin
    result = total[LANE_W-1:0];
    if (pos_ovf) result = {1'b0, {(LANE_W-1){1'b1}}};
    else if (neg_ovf) result = {1'b1, {(LANE_W-1){1'b0}}};
  end

endmodule

// File: rtl/axis_noise_generator.sv
// AXI4-Stream additive-noise injector: adds scaled pseudo-Gaussian noise to
// the I and Q lanes of each beat through a single output register stage.
module axis_noise_generator
  import axis_noise_generator_pkg::*;
#(
  parameter logic [LANE_W-1:0] SEED_I = SEED_I_DEFAULT,
  parameter logic [LANE_W-1:0] SEED_Q = SEED_Q_DEFAULT
) (
  input  logic        m00_axis_aclk_0,
  input  logic        m00_axis_areset_0,
  input  logic [31:0] scale_factor_0,
  input  logic [63:0] S00_AXIS_0_tdata,
  input  logic        S00_AXIS_0_tvalid,
  output logic        S00_AXIS_0_tready,
  input  logic        S00_AXIS_0_tlast,
  input  logic [7:0]  S00_AXIS_0_tstrb,
  output logic [63:0] M00_AXIS_0_tdata,
  output logic        M00_AXIS_0_tvalid,
  input  logic        M00_AXIS_0_tready,
  output logic        M00_AXIS_0_tlast,
  output logic [7:0]  M00_AXIS_0_tstrb
);

  logic        accept;
  lane_t       noisy_i;
  lane_t       noisy_q;
  logic        unused_bits;

  assign unused_bits = ^{scale_factor_0[31:SHIFT_W], S00_AXIS_0_tstrb};

  // Reset gating keeps the source stalled while the pipeline is being cleared.
  assign S00_AXIS_0_tready = !m00_axis_areset_0
                           && (!M00_AXIS_0_tvalid || M00_AXIS_0_tready);
  assign accept            = S00_AXIS_0_tvalid && S00_AXIS_0_tready;
  assign M00_AXIS_0_tstrb  = 8'hFF;

  axis_noise_generator_noise_lane #(.SEED(SEED_I)) lane_i (
    .clk     (m00_axis_aclk_0),
    .reset   (m00_axis_areset_0),
    .advance (accept),
    .shift   (scale_factor_0[SHIFT_W-1:0]),
    .sample  (S00_AXIS_0_tdata[31:0]),
    .result  (noisy_i)
  );

  axis_noise_generator_noise_lane #(.SEED(SEED_Q)) lane_q (
    .clk     (m00_axis_aclk_0),
    .reset   (m00_axis_areset_0),
    .advance (accept),
    .shift   (scale_factor_0[SHIFT_W-1:0]),
    .sample  (S00_AXIS_0_tdata[63:32]),
    .result  (noisy_q)
  );

  always_ff @(posedge m00_axis_aclk_0) begin
    if (m00_axis_areset_0) begin
      M00_AXIS_0_tvalid <= 1'b0;
      M00_AXIS_0_tdata  <= '0;
      M00_AXIS_0_tlast  <= 1'b0;
    end else if (accept) begin
      M00_AXIS_0_tvalid <= 1'b1;
      M00_AXIS_0_tdata  <= {noisy_q, noisy_i};
      M00_AXIS_0_tlast  <= S00_AXIS_0_tlast;
    end else if (M00_AXIS_0_tready) begin
      M00_AXIS_0_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_noise_generator.sv
// Directed bench for axis_noise_generator: hand-computed beats, then a long
// ramp with a stall checked against a small behavioural noise model.
module tb_axis_noise_generator;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] scale;
  logic [63:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic        s_tlast;
  logic [63:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic [7:0]  m_tstrb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axis_noise_generator dut (
    .m00_axis_aclk_0   (clk),
    .m00_axis_areset_0 (reset),
    .scale_factor_0    (scale),
    .S00_AXIS_0_tdata  (s_tdata),
    .S00_AXIS_0_tvalid (s_tvalid),
    .S00_AXIS_0_tready (s_tready),
    .S00_AXIS_0_tlast  (s_tlast),
    .S00_AXIS_0_tstrb  (8'h00),
    .M00_AXIS_0_tdata  (m_tdata),
    .M00_AXIS_0_tvalid (m_tvalid),
    .M00_AXIS_0_tready (m_tready),
    .M00_AXIS_0_tlast  (m_tlast),
    .M00_AXIS_0_tstrb  (m_tstrb)
  );

  function automatic logic [31:0] modelStep(input logic [31:0] r);
    return r[0] ? ((r >> 1) ^ 32'h8020_0003) : (r >> 1);
  endfunction

  function automatic int modelNoise(input logic [31:0] r);
    int s = 0;
    for (int b = 0; b < 4; b++) s += int'($signed(r[8*b +: 8]));
    return s;
  endfunction

  function automatic logic [31:0] modelLane(input logic [31:0] x, input logic [31:0] r,
                                            input int sh);
    longint v;
    v = longint'($signed(x)) + (longint'(modelNoise(r)) <<< sh);
    if (v > 64'sd2147483647) v = 64'sd2147483647;
    if (v < -64'sd2147483648) v = -64'sd2147483648;
    return v[31:0];
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [63:0] data, input logic last,
                               input logic [31:0] sc, input logic mready);
    @(negedge clk);
    s_tvalid = valid;
    s_tdata  = data;
    s_tlast  = last;
    scale    = sc;
    m_tready = mready;
    #1;
  endtask

  logic [64:0] expQ[$];
  logic [64:0] expBeat;
  logic [63:0] held;
  logic [31:0] mi, mq;
  int k, cyc, accepted, popped, lastSeen;

  initial begin
    reset = 1'b1; s_tvalid = 1'b1; s_tdata = '0; s_tlast = 1'b0; scale = 32'd2; m_tready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_tvalid", {63'd0, m_tvalid}, 64'd0);
    checkOutput("reset_tdata", m_tdata, 64'd0);
    checkOutput("reset_tlast", {63'd0, m_tlast}, 64'd0);
    checkOutput("reset_s_tready", {63'd0, s_tready}, 64'd0);
    checkOutput("tstrb", {56'd0, m_tstrb}, 64'hFF);
    reset = 1'b0; s_tvalid = 1'b0;

    applyStimulus(1'b1, 64'd0, 1'b0, 32'd2, 1'b1);
    applyStimulus(1'b0, 64'd0, 1'b0, 32'd0, 1'b1);
    checkOutput("beat1_valid", {63'd0, m_tvalid}, 64'd1);
    checkOutput("beat1_data", m_tdata, 64'hFFFF_FF90_0000_0064);
    checkOutput("beat1_last", {63'd0, m_tlast}, 64'd0);
    applyStimulus(1'b0, 64'd0, 1'b0, 32'd0, 1'b1);
    checkOutput("valid_drop", {63'd0, m_tvalid}, 64'd0);
    repeat (8) applyStimulus(1'b0, 64'd0, 1'b0, 32'd0, 1'b1);

    applyStimulus(1'b1, {32'h8000_0005, 32'h7FFF_FFF0}, 1'b0, 32'd0, 1'b1);
    applyStimulus(1'b1, {32'hFFFF_FC18, 32'h0000_03E8}, 1'b0, 32'd4, 1'b1);
    checkOutput("beat2_saturate", m_tdata, {32'h8000_0000, 32'h7FFF_FFFF});
    applyStimulus(1'b1, 64'd0, 1'b0, 32'd31, 1'b1);
    checkOutput("beat3_shift4", m_tdata, {32'hFFFF_FA68, 32'h0000_1048});
    applyStimulus(1'b1, 64'd0, 1'b1, 32'd0, 1'b1);
    checkOutput("beat4_shift31", m_tdata, {32'h7FFF_FFFF, 32'h8000_0000});
    checkOutput("beat4_last", {63'd0, m_tlast}, 64'd0);

    applyStimulus(1'b1, 64'h0000_0000_0000_1234, 1'b0, 32'd0, 1'b0);
    checkOutput("beat5_data", m_tdata, {32'hFFFF_FFD9, 32'hFFFF_FFCF});
    checkOutput("beat5_last", {63'd0, m_tlast}, 64'd1);
    checkOutput("stall_s_tready", {63'd0, s_tready}, 64'd0);
    repeat (3) begin
      applyStimulus(1'b1, 64'h0000_0000_0000_1234, 1'b0, 32'd0, 1'b0);
      checkOutput("stall_hold", {m_tdata[63:1], m_tlast}, {32'hFFFF_FFD9, 31'h7FFF_FFE7, 1'b1});
    end
    applyStimulus(1'b1, 64'h0000_0000_0000_1234, 1'b0, 32'd0, 1'b1);
    applyStimulus(1'b0, 64'd0, 1'b0, 32'd0, 1'b1);
    checkOutput("beat6_valid", {63'd0, m_tvalid}, 64'd1);
    checkOutput("beat6_after_stall", m_tdata, {32'hFFFF_FF6B, 32'h0000_127A});

    // Ramp 0..1040 with a 30-cycle downstream stall, checked against the model.
    mi = 32'hACE1_2468;
    mq = 32'h1357_9BDF;
    repeat (6) begin
      mi = modelStep(mi);
      mq = modelStep(mq);
    end
    k = 0; cyc = 0; accepted = 0; popped = 0; lastSeen = 0;
    while ((k <= 1040 || expQ.size() != 0) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      m_tready = !(cyc >= 600 && cyc < 630);
      s_tvalid = (k <= 1040);
      s_tdata  = {32'(-k), 32'(k)};
      s_tlast  = (k == 1040);
      scale    = 32'(k % 24);
      #1;
      if (cyc == 600) held = m_tdata;
      if (cyc >= 600 && cyc < 630) begin
        checkOutput("ramp_stall_tready", {63'd0, s_tready}, 64'd0);
        checkOutput("ramp_stall_hold", m_tdata, held);
      end
      if (m_tvalid && m_tready) begin
        if (expQ.size() == 0) begin
          checkOutput("ramp_unexpected_output", 64'd1, 64'd0);
        end else begin
          expBeat = expQ.pop_front();
          checkOutput("ramp_beat", m_tdata, expBeat[63:0]);
          checkOutput("ramp_last", {63'd0, m_tlast}, {63'd0, expBeat[64]});
          popped++;
          if (m_tlast) lastSeen++;
        end
      end
      if (s_tvalid && s_tready) begin
        expQ.push_back({s_tlast, modelLane(s_tdata[63:32], mq, k % 24),
                                 modelLane(s_tdata[31:0], mi, k % 24)});
        mi = modelStep(mi);
        mq = modelStep(mq);
        accepted++;
        k++;
      end
    end
    s_tvalid = 1'b0;
    checkOutput("ramp_accepted", 64'(accepted), 64'd1041);
    checkOutput("ramp_outputs", 64'(popped), 64'd1041);
    checkOutput("ramp_tlast_count", 64'(lastSeen), 64'd1);
    checkOutput("ramp_cycles", 64'(cyc), 64'd1072);

    // Reset mid-frame, then the first beat must repeat exactly.
    applyStimulus(1'b1, 64'd5, 1'b0, 32'd3, 1'b1);
    applyStimulus(1'b1, 64'd6, 1'b0, 32'd3, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("midreset_s_tready", {63'd0, s_tready}, 64'd0);
    repeat (2) @(negedge clk);
    #1;
    checkOutput("midreset_tvalid", {63'd0, m_tvalid}, 64'd0);
    checkOutput("midreset_tdata", m_tdata, 64'd0);
    reset = 1'b0; s_tvalid = 1'b0;
    applyStimulus(1'b1, 64'd0, 1'b0, 32'd2, 1'b1);
    applyStimulus(1'b0, 64'd0, 1'b0, 32'd0, 1'b1);
    checkOutput("reseed_valid", {63'd0, m_tvalid}, 64'd1);
    checkOutput("reseed_data", m_tdata, 64'hFFFF_FF90_0000_0064);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
